// File: rtl/branch_ckpt_ctrl_pkg.sv
// Shared types for the branch-checkpoint controller: slot record, FSM states and
// the default slot geometry.
package branch_ckpt_ctrl_pkg;

  localparam int ROB_W    = 6;
  localparam int CKPT_NUM = 4;
  localparam int CKPT_W   = $clog2(CKPT_NUM);

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] tag;
  } ckpt_slot_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOVER = 2'd1,
    SETTLE  = 2'd2
  } ckpt_fsm_e;

endpackage

// File: rtl/ckpt_tag_cam.sv
// Fully associative tag match over the checkpoint slots; returns a hit flag and
// the encoded index of the matching valid slot.
module ckpt_tag_cam
  import branch_ckpt_ctrl_pkg::*;
#(
  parameter  int NUM   = CKPT_NUM,
  parameter  int TAG_W = ROB_W,
  localparam int IDX_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]       i_valid,
  input  logic [NUM*TAG_W-1:0] i_tags,
  input  logic [TAG_W-1:0]     i_tag,
  output logic                 o_hit,
  output logic [IDX_W-1:0]     o_idx
);

  // Live tags are unique, so at most one slot can match.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = 0; i < NUM; i++) begin
      if (i_valid[i] && (i_tags[i*TAG_W +: TAG_W] == i_tag)) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/branch_ckpt_ctrl.sv
// Branch-checkpoint slot owner: allocates slots at dispatch, frees them in age
// order on correct resolves, and sequences mispredict recovery (pulse + settle).
module branch_ckpt_ctrl
  import branch_ckpt_ctrl_pkg::*;
#(
  parameter  int NUM_CKPT   = CKPT_NUM,
  parameter  int SETTLE_CYC = 2,
  localparam int SLOT_W     = $clog2(NUM_CKPT),
  localparam int CNT_W      = SLOT_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              disp_valid_i,
  input  logic              disp_is_br_i,
  input  logic [ROB_W-1:0]  disp_rob_tag_i,
  input  logic              rob_ready_i,
  output logic              disp_stall_o,
  output logic              ckpt_take_o,
  output logic [ROB_W-1:0]  ckpt_tag_o,
  output logic [SLOT_W-1:0] ckpt_slot_o,
  input  logic              bru_valid_i,
  input  logic [ROB_W-1:0]  bru_rob_tag_i,
  input  logic              bru_mispred_i,
  output logic              recover_o,
  output logic [ROB_W-1:0]  recover_tag_o,
  output logic [SLOT_W-1:0] recover_slot_o,
  output logic [CNT_W-1:0]  free_cnt_o
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  ckpt_slot_t          r_slot [NUM_CKPT];
  logic [SLOT_W-1:0]   r_head, r_tail;
  logic [CNT_W-1:0]    r_count;
  ckpt_fsm_e           r_state;
  logic [SET_W-1:0]    r_settle_cnt;
  logic [ROB_W-1:0]    r_rec_tag;
  logic [SLOT_W-1:0]   r_rec_slot;

  ckpt_fsm_e           w_state_nxt;
  logic [SET_W-1:0]    w_settle_nxt;
  logic [NUM_CKPT-1:0] w_valid, w_valid_nxt;
  logic [NUM_CKPT*ROB_W-1:0] w_tags;
  logic                w_hit;
  logic [SLOT_W-1:0]   w_hit_idx;
  logic                w_full, w_br_fire, w_alloc;
  logic                w_res_ok, w_mis, w_good;
  logic [SLOT_W-1:0]   w_age_s;
  logic [CNT_W-1:0]    w_lim, w_skip, w_count_nxt;
  logic                w_stop;
  logic [SLOT_W-1:0]   w_head_nxt, w_tail_nxt;

  always_comb begin
    for (int i = 0; i < NUM_CKPT; i++) begin
      w_valid[i]                  = r_slot[i].valid;
      w_tags[i*ROB_W +: ROB_W]    = r_slot[i].tag;
    end
  end

  ckpt_tag_cam #(
    .NUM   (NUM_CKPT),
    .TAG_W (ROB_W)
  ) u_cam (
    .i_valid (w_valid),
    .i_tags  (w_tags),
    .i_tag   (bru_rob_tag_i),
    .o_hit   (w_hit),
    .o_idx   (w_hit_idx)
  );

  // Dispatch side: stall uses registered count, so a same-cycle free never unblocks.
  assign w_full       = (r_count == CNT_W'(NUM_CKPT));
  assign disp_stall_o = (r_state != IDLE) || (disp_valid_i && disp_is_br_i && w_full);
  assign w_br_fire    = disp_valid_i && disp_is_br_i && rob_ready_i && !disp_stall_o && !flush_i;
  assign ckpt_take_o  = w_br_fire;
  assign ckpt_tag_o   = w_br_fire ? disp_rob_tag_i : '0;
  assign ckpt_slot_o  = w_br_fire ? r_tail : '0;

  assign w_res_ok = bru_valid_i && w_hit && (r_state != RECOVER);
  assign w_mis    = w_res_ok && bru_mispred_i;
  assign w_good   = w_res_ok && !bru_mispred_i;
  // A branch dispatched alongside an accepted mispredict is younger and gets squashed.
  assign w_alloc  = w_br_fire && !w_mis;
  assign w_age_s  = w_hit_idx - r_head;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_valid_nxt = w_valid;
    w_lim       = r_count;
    if (w_good) begin
      w_valid_nxt[w_hit_idx] = 1'b0;
    end
    if (w_mis) begin
      for (int j = 0; j < NUM_CKPT; j++) begin
        if ((SLOT_W'(j) - r_head) >= w_age_s) begin
          w_valid_nxt[j] = 1'b0;
        end
      end
      w_lim = {1'b0, w_age_s};
    end
    // Head walks over the run of dead slots among the surviving older entries.
    w_skip = '0;
    w_stop = 1'b0;
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (!w_stop) begin
        if ((CNT_W'(k) < w_lim) && !w_valid_nxt[r_head + SLOT_W'(k)]) begin
          w_skip = w_skip + 1'b1;
        end else begin
          w_stop = 1'b1;
        end
      end
    end
    w_head_nxt  = r_head + w_skip[SLOT_W-1:0];
    w_count_nxt = w_lim - w_skip + CNT_W'(w_alloc);
    w_tail_nxt  = w_mis ? w_hit_idx : (w_alloc ? r_tail + 1'b1 : r_tail);
    if (w_alloc) begin
      w_valid_nxt[r_tail] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_mis) w_state_nxt = RECOVER;
      end
      RECOVER: begin
        w_state_nxt  = SETTLE;
        w_settle_nxt = '0;
      end
      SETTLE: begin
        if (w_mis) begin
          w_state_nxt = RECOVER;
        end else if (r_settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
          w_state_nxt = IDLE;
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the slot array is tiny, so the whole record is reset rather than only valid bits.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        r_slot[i] <= '0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= IDLE;
      r_settle_cnt <= '0;
      if (!rst_n) begin
        r_rec_tag  <= '0;
        r_rec_slot <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        r_slot[i].valid <= w_valid_nxt[i];
      end
      if (w_alloc) begin
        r_slot[r_tail].tag <= disp_rob_tag_i;
      end
      if (w_mis) begin
        r_rec_tag  <= bru_rob_tag_i;
        r_rec_slot <= w_hit_idx;
      end
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_count      <= w_count_nxt;
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  assign recover_o      = (r_state == RECOVER) && !flush_i;
  assign recover_tag_o  = recover_o ? r_rec_tag : '0;
  assign recover_slot_o = recover_o ? r_rec_slot : '0;
  assign free_cnt_o     = CNT_W'(NUM_CKPT) - r_count;

endmodule

// File: doc/branch_ckpt_ctrl.md
Name: branch_ckpt_ctrl

Overview:
Controller that owns the branch-checkpoint slots for speculative recovery. It allocates a slot when dispatch sends a branch, and drives the ROB/rename checkpoint-take strobe with that branch's ROB tag. It also tracks slots in age order, releases a slot on a correct resolution, and sequences mispredict recovery: a one-cycle recover pulse, then a settle window with dispatch stalled. It sits between dispatch, the BRU writeback and the ROB/rename recover inputs.

Parameters:
NUM_CKPT, 4, number of checkpoint slots (power of two, ≥2)
SETTLE_CYC, 2, dispatch-stall cycles after the recover pulse (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush_i  in  1  full pipeline flush
disp_valid_i  in  1  dispatch presents an instruction
disp_is_br_i  in  1  instruction needs a checkpoint
disp_rob_tag_i  in  ROB_W  ROB tag of the dispatching instruction
rob_ready_i  in  1  ROB can allocate
disp_stall_o  out  1  dispatch must hold this cycle
ckpt_take_o  out  1  take checkpoint for ckpt_tag_o (to ROB/rename)
ckpt_tag_o  out  ROB_W  ROB tag of the checkpointed branch
ckpt_slot_o  out  CKPT_W  slot index for the rename map snapshot
bru_valid_i  in  1  branch resolved
bru_rob_tag_i  in  ROB_W  tag of the resolved branch
bru_mispred_i  in  1  resolution was a mispredict
recover_o  out  1  one-cycle recover strobe
recover_tag_o  out  ROB_W  tag to restore
recover_slot_o  out  CKPT_W  slot to restore the map from
free_cnt_o  out  CKPT_W+1  free slot count

Behaviour:
- Slot storage: per slot {valid, tag}. Circular age FIFO with head (oldest) and tail (next alloc) of CKPT_W bits, plus count of CKPT_W+1 bits. free_cnt_o = NUM_CKPT − count.
- Reset values: all slots invalid; head = tail = 0; count = 0; FSM = IDLE; settle counter = 0. After reset, every output is 0 except free_cnt_o = NUM_CKPT.
- FSM states:
  - IDLE: normal operation.
  - RECOVER: lasts exactly 1 cycle; recover_o = 1.
  - SETTLE: lasts SETTLE_CYC cycles, then returns to IDLE.
- disp_stall_o is combinational. It is 1 when FSM ≠ IDLE, or when (disp_valid_i && disp_is_br_i && count == NUM_CKPT).
- Dispatch fire: disp_valid_i && rob_ready_i && !disp_stall_o.
- On a branch dispatch fire:
  - ckpt_take_o = 1 in the same cycle (combinational); ckpt_tag_o = disp_rob_tag_i; ckpt_slot_o = tail.
  - Next cycle: slot[tail] ← {1, tag}; tail + 1 (wraps modulo NUM_CKPT); count + 1.
  - When ckpt_take_o = 0, ckpt_tag_o and ckpt_slot_o = 0.
- Resolve lookup: a CAM compares bru_rob_tag_i against the tag of every valid slot. No hit means the branch was already squashed; the resolution is ignored with no state change.
- Correct resolve (hit, !mispred): clear that slot's valid bit. head then advances past every contiguous invalid slot, and count decrements by the number of slots head skips. Slots freed out of order stay reserved until they become oldest.
- Mispredict (hit slot s, accepted in IDLE or SETTLE):
  - Latch tag and s.
  - Invalidate slot s and every slot younger than it, from s to tail−1.
  - tail ← s; count ← (s − head) mod NUM_CKPT, unless every older slot is already invalid, in which case head ← s as well.
  - Next cycle: RECOVER, with recover_tag_o = latched tag and recover_slot_o = s. Both outputs are 0 when recover_o = 0.
  - The controller owns no PC; the frontend redirect comes from the BRU.
- Mispredict during SETTLE: a hit is necessarily older than the slot just recovered, because younger slots are already invalid. It restarts the sequence, going back to RECOVER next cycle.
- Resolves during the RECOVER cycle are ignored; the BRU must squash younger in-flight branches on that strobe.
- Simultaneous branch dispatch and resolve in IDLE: both take effect. Count nets +1−k for k slots freed; the resolve lookup does not see the slot being allocated that cycle.
- Dispatch while count == NUM_CKPT but the same-cycle resolve frees a slot: dispatch still stalls, because the stall is computed from registered count.
- flush_i: has priority over everything except reset. Invalidates all slots; head = tail = count = 0; FSM → IDLE. recover_o and ckpt_take_o are forced to 0 that cycle.
- Reset in RECOVER or SETTLE returns to the reset state next cycle; recover_o must not pulse after reset.

Decomposition:
- Shared package ooop_types gets CKPT_W = $clog2(NUM_CKPT) and a ckpt_slot_t struct {valid, tag}.
- Add enum ckpt_fsm_e {IDLE, RECOVER, SETTLE} to checkpoint_types.
- One sub-module, ckpt_tag_cam: NUM_CKPT-way tag match giving a hit flag plus a one-hot or encoded slot index.

Test Plan:
- Reset → free_cnt_o = 4, all other outputs 0; one branch dispatch with tag 5 → ckpt_take_o = 1, ckpt_slot_o = 0, free_cnt_o = 3 next cycle.
- Dispatch branches with tags 1, 2, 3, 4; a 5th branch has disp_valid_i high → disp_stall_o = 1, no ckpt_take_o; resolve tag 1 correct → free_cnt_o = 1; the 5th branch dispatches the following cycle into slot 0.
- Out-of-order free: slots hold tags 1, 2, 3; resolve tag 2 correct → free_cnt unchanged (1); resolve tag 1 correct → head jumps to slot 2, free_cnt_o = 3.
- Mispredict tag 2 with tags 1, 2, 3 live → next cycle recover_o = 1, recover_tag_o = 2, recover_slot_o = 1; disp_stall_o high for 1 + 2 cycles; free_cnt_o = 3; a later resolve of tag 3 is ignored.
- During SETTLE, mispredict tag 1 → recover_o re-pulses with tag 1, slot 0; free_cnt_o = 4.
- flush_i in SETTLE → next cycle IDLE, free_cnt_o = 4, disp_stall_o = 0; reset asserted mid-RECOVER → no further recover_o pulse.
